// File: rtl/md_issue_ctrl_pkg.sv
// Shared definitions for the multiply/divide issue controller: the mt* op
// codes understood by the HI/LO unit, the controller state encoding and a
// helper that identifies the single-cycle HI/LO write ops.
package md_issue_ctrl_pkg;

    localparam int MT_W = 4;

    // Op codes shared with the decoder and the multiply/divide unit.
    localparam logic [MT_W-1:0] mtNone  = 4'd0;
    localparam logic [MT_W-1:0] mtMult  = 4'd1;
    localparam logic [MT_W-1:0] mtMultU = 4'd2;
    localparam logic [MT_W-1:0] mtDiv   = 4'd3;
    localparam logic [MT_W-1:0] mtDivU  = 4'd4;
    localparam logic [MT_W-1:0] mtMAdd  = 4'd5;
    localparam logic [MT_W-1:0] mtMAddU = 4'd6;
    localparam logic [MT_W-1:0] mtMSub  = 4'd7;
    localparam logic [MT_W-1:0] mtMSubU = 4'd8;
    localparam logic [MT_W-1:0] mtSetHI = 4'd9;
    localparam logic [MT_W-1:0] mtSetLO = 4'd10;

    typedef enum logic [1:0] {
        MDI_IDLE  = 2'd0,
        MDI_ISSUE = 2'd1,
        MDI_WAIT  = 2'd2
    } mdi_state_e;

    // mthi/mtlo write HI/LO at the issue edge and never raise busy.
    function automatic logic is_set_op(input logic [MT_W-1:0] ctrl);
        return (ctrl == mtSetHI) || (ctrl == mtSetLO);
    endfunction

endpackage

// File: rtl/md_issue_ctrl.sv
// EX-stage front end for the HI/LO multiply/divide unit.
// Buffers one MD op, issues exactly one start pulse per op, follows the
// unit's busy to know when HI/LO are valid, gates mfhi/mflo reads and
// produces the pipeline stall.
// Build option: define MD_FORWARD_EN to forward the mthi/mtlo operand to a
// read of the same register during the issue cycle (removes one bubble).
module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
#(
    parameter int CTRL_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    input  logic [CTRL_W-1:0] op_ctrl,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              op_ready,
    input  logic              rd_req,
    input  logic              rd_sel,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              stall,
    input  logic              flush,
    output logic              md_start,
    output logic [CTRL_W-1:0] md_ctrl,
    output logic [DATA_W-1:0] md_a,
    output logic [DATA_W-1:0] md_b,
    input  logic              md_busy,
    input  logic [DATA_W-1:0] md_hi,
    input  logic [DATA_W-1:0] md_lo
);

    mdi_state_e        state;
    logic              hv;
    logic [CTRL_W-1:0] h_ctrl;
    logic [DATA_W-1:0] h_a;
    logic [DATA_W-1:0] h_b;

    logic accept;
    logic h_set;
    logic idle_empty;

    // A flush in the same cycle blocks acceptance of the presented op.
    assign accept     = op_valid & op_ready & ~flush;
    assign h_set      = is_set_op(MT_W'(h_ctrl));
    assign idle_empty = (state == MDI_IDLE) & ~hv;

    // Holding buffer: captures an accepted op, empties at the issue edge or on flush.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hv     <= 1'b0;
            h_ctrl <= '0;
            h_a    <= '0;
            h_b    <= '0;
        end else if (flush) begin
            hv <= 1'b0;
        end else if (accept) begin
            hv     <= 1'b1;
            h_ctrl <= op_ctrl;
            h_a    <= op_a;
            h_b    <= op_b;
        end else if (state == MDI_ISSUE) begin
            hv <= 1'b0;
        end
    end

    // Issue FSM: start from IDLE, wait on busy for multi-cycle ops.
    // An op accepted while IDLE is issued in the very next cycle; an op that
    // was buffered behind a busy unit issues one cycle after returning to IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MDI_IDLE;
        end else begin
            case (state)
                MDI_IDLE: begin
                    if ((hv & ~flush) | accept) begin
                        state <= MDI_ISSUE;
                    end
                end
                MDI_ISSUE: begin
                    // Set ops complete at this edge; everything else waits on busy.
                    if (flush | h_set) begin
                        state <= MDI_IDLE;
                    end else begin
                        state <= MDI_WAIT;
                    end
                end
                MDI_WAIT: begin
                    // The unit cannot abort, so flush does not shorten the wait.
                    if (!md_busy) begin
                        state <= MDI_IDLE;
                    end
                end
                default: state <= MDI_IDLE;
            endcase
        end
    end

    assign op_ready = ~hv;
    assign md_start = (state == MDI_ISSUE) & ~flush;
    assign md_ctrl  = h_ctrl;
    assign md_a     = h_a;
    assign md_b     = h_b;

`ifdef MD_FORWARD_EN
    logic fwd_hit;
    logic fwd_is_hi;

    // During the issue cycle of mthi/mtlo the new value is already known.
    assign fwd_hit   = (state == MDI_ISSUE) & h_set & ~flush;
    assign fwd_is_hi = (MT_W'(h_ctrl) == mtSetHI);
    assign rd_valid  = idle_empty | fwd_hit;
    assign rd_data   = (fwd_hit && (rd_sel == fwd_is_hi)) ? h_a
                                                          : (rd_sel ? md_hi : md_lo);
`else
    assign rd_valid  = idle_empty;
    assign rd_data   = rd_sel ? md_hi : md_lo;
`endif

    // A flushed read is discarded by the pipeline, so it must not stall.
    assign stall = (op_valid & ~op_ready) | (rd_req & ~rd_valid & ~flush);

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl with a behavioural HI/LO unit and a
// cycle-count reference model of issue, completion and read validity.
module tb_md_issue_ctrl;
    import md_issue_ctrl_pkg::*;

    localparam int CTRL_W = 4;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              op_valid = 1'b0;
    logic [CTRL_W-1:0] op_ctrl = '0;
    logic [DATA_W-1:0] op_a = '0;
    logic [DATA_W-1:0] op_b = '0;
    logic              op_ready;
    logic              rd_req = 1'b0;
    logic              rd_sel = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              stall;
    logic              flush = 1'b0;
    logic              md_start;
    logic [CTRL_W-1:0] md_ctrl;
    logic [DATA_W-1:0] md_a;
    logic [DATA_W-1:0] md_b;
    logic              md_busy;
    logic [DATA_W-1:0] md_hi;
    logic [DATA_W-1:0] md_lo;

    md_issue_ctrl #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_ctrl(op_ctrl), .op_a(op_a), .op_b(op_b),
        .op_ready(op_ready),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data), .rd_valid(rd_valid),
        .stall(stall), .flush(flush),
        .md_start(md_start), .md_ctrl(md_ctrl), .md_a(md_a), .md_b(md_b),
        .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Architectural effect of one op on the 64-bit {HI,LO} pair.
    function automatic logic [63:0] md_compute(input logic [3:0] c, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] hilo);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (c)
            mtMult:  return sa * sb;
            mtMultU: return ua * ub;
            mtDiv:   return (b == 0) ? hilo : {32'(sa % sb), 32'(sa / sb)};
            mtDivU:  return (b == 0) ? hilo : {32'(ua % ub), 32'(ua / ub)};
            mtMAdd:  return hilo + sa * sb;
            mtMAddU: return hilo + ua * ub;
            mtMSub:  return hilo - sa * sb;
            mtMSubU: return hilo - ua * ub;
            mtSetHI: return {a, hilo[31:0]};
            mtSetLO: return {hilo[63:32], a};
            default: return hilo;
        endcase
    endfunction

    function automatic bit is_div(input logic [3:0] c);
        return (c == mtDiv) || (c == mtDivU);
    endfunction

    // Cycles from the start cycle until a read of HI/LO is valid.
    function automatic int op_latency(input logic [3:0] c);
        if (is_set_op(c)) return 1;
        if (is_div(c))    return 10;
        return 5;
    endfunction

    // Behavioural multiply/divide unit: busy 3 (mult) or 8 (div) cycles.
    logic        u_busy;
    int          u_cnt;
    logic [63:0] u_hilo;
    logic [63:0] u_res;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            u_busy <= 1'b0;
            u_cnt  <= 0;
            u_hilo <= '0;
            u_res  <= '0;
        end else if (md_start) begin
            if (is_set_op(md_ctrl)) begin
                u_hilo <= md_compute(md_ctrl, md_a, md_b, u_hilo);
            end else begin
                u_busy <= 1'b1;
                u_cnt  <= is_div(md_ctrl) ? 8 : 3;
                u_res  <= md_compute(md_ctrl, md_a, md_b, u_hilo);
            end
        end else if (u_busy) begin
            if (u_cnt == 1) begin
                u_busy <= 1'b0;
                u_hilo <= u_res;
            end else begin
                u_cnt <= u_cnt - 1;
            end
        end
    end

    assign md_busy = u_busy;
    assign md_hi   = u_hilo[63:32];
    assign md_lo   = u_hilo[31:0];

    // Reference model: buffered ops with their issue cycle, the cycle the
    // controller becomes free again, and the architectural {HI,LO}.
    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        int          issue_at;
    } op_t;

    op_t         pend[$];
    int          t = 0;
    int          busy_until = 0;
    logic [63:0] m_hilo = '0;

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step(input logic ov, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic rq, input logic rs, input logic fl);
        bit          has, issuing, fwd, exp_valid, exp_stall;
        op_t         head, n;
        logic [31:0] exp_data;
        @(negedge clk);
        op_valid = ov; op_ctrl = c; op_a = a; op_b = b;
        rd_req = rq; rd_sel = rs; flush = fl;
        #1;
        has = (pend.size() != 0);
        head = '{ctrl: '0, a: '0, b: '0, issue_at: 0};
        if (has) head = pend[0];
        issuing = has && (head.issue_at <= t);
        fwd = 1'b0;
`ifdef MD_FORWARD_EN
        fwd = issuing && !fl && is_set_op(head.ctrl);
`endif
        exp_valid = (!has && (t >= busy_until)) || fwd;
        exp_stall = (ov && has) || (rq && !exp_valid && !fl);
        check("op_ready", op_ready, !has);
        check("md_start", md_start, issuing && !fl);
        check("rd_valid", rd_valid, exp_valid);
        check("stall", stall, exp_stall);
        if (has) begin
            check("md_ctrl", md_ctrl, head.ctrl);
            check("md_a", md_a, head.a);
            check("md_b", md_b, head.b);
        end
        if (exp_valid) begin
            if (fwd && (rs == (head.ctrl == mtSetHI)))
                exp_data = head.a;
            else
                exp_data = rs ? m_hilo[63:32] : m_hilo[31:0];
            check("rd_data", rd_data, exp_data);
        end
        if (fl) begin
            pend.delete();
        end else if (issuing) begin
            void'(pend.pop_front());
            m_hilo     = md_compute(head.ctrl, head.a, head.b, m_hilo);
            busy_until = t + op_latency(head.ctrl);
        end else if (ov && !has) begin
            n.ctrl = c; n.a = a; n.b = b;
            n.issue_at = ((t > busy_until) ? t : busy_until) + 1;
            pend.push_back(n);
        end
        t++;
    endtask

    // Hold op_valid until the op is taken (bounded), reading via rs meanwhile.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic rs);
        bit took;
        took = 1'b0;
        for (int i = 0; i < 40 && !took; i++) begin
            took = (pend.size() == 0);
            step(1'b1, c, a, b, 1'b1, rs, 1'b0);
        end
        check("issue_taken", took, 1'b1);
    endtask

    task automatic idle(input int n, input logic rs);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b1, rs, 1'b0);
    endtask

    // Issue an op into an idle controller and measure start-to-valid cycles.
    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat);
        int s_at, lat;
        s_at = -1;
        lat  = -1;
        issue(c, a, b, 1'b0);
        for (int i = 0; i < 30 && lat < 0; i++) begin
            step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
            if (md_start) s_at = t - 1;
            else if (s_at >= 0 && rd_valid) lat = (t - 1) - s_at;
        end
        check(tag, lat, exp_lat);
    endtask

    task automatic read_const(input string tag, input logic rs, input logic [31:0] exp);
        step(1'b0, '0, '0, '0, 1'b1, rs, 1'b0);
        check(tag, rd_data, exp);
    endtask

    logic [3:0] codes [10] = '{mtMult, mtMultU, mtDiv, mtDivU, mtMAdd,
                               mtMAddU, mtMSub, mtMSubU, mtSetHI, mtSetLO};

    initial begin
        // Reset state
        #1;
        check("rst_op_ready", op_ready, 1'b1);
        check("rst_rd_valid", rd_valid, 1'b1);
        check("rst_md_start", md_start, 1'b0);
        check("rst_stall", stall, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        idle(2, 1'b0);

        // mult 3 * -2
        run_op("mult_latency", mtMult, 32'd3, 32'hFFFF_FFFE, 5);
        read_const("mult_hi", 1'b1, 32'hFFFF_FFFF);
        read_const("mult_lo", 1'b0, 32'hFFFF_FFFA);

        // div 7/2, then div followed back-to-back by mult 4*5
        run_op("div_latency", mtDiv, 32'd7, 32'd2, 10);
        read_const("div_hi", 1'b1, 32'd1);
        read_const("div_lo", 1'b0, 32'd3);
        issue(mtDiv, 32'd9, 32'd4, 1'b0);
        issue(mtMult, 32'd4, 32'd5, 1'b0);
        idle(14, 1'b0);
        read_const("b2b_lo", 1'b0, 32'd20);
        read_const("b2b_hi", 1'b1, 32'd0);

        // mthi then mfhi in the next cycle
        issue(mtSetHI, 32'h1234, 32'd0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0);
`ifdef MD_FORWARD_EN
        check("mthi_fwd_stall", stall, 1'b0);
        check("mthi_fwd_data", rd_data, 32'h1234);
`else
        check("mthi_bubble", stall, 1'b1);
`endif
        read_const("mthi_data", 1'b1, 32'h1234);

        // flush in the issue cycle drops the op; flush during WAIT does not
        issue(mtMult, 32'd5, 32'd6, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
        check("flush_no_start", md_start, 1'b0);
        read_const("flush_hi_kept", 1'b1, 32'h1234);
        issue(mtDivU, 32'd100, 32'd7, 1'b0);
        idle(2, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b1);
        idle(12, 1'b0);
        read_const("flush_wait_lo", 1'b0, 32'd14);

        // asynchronous reset in the middle of WAIT
        issue(mtDiv, 32'd50, 32'd3, 1'b0);
        idle(3, 1'b0);
        @(posedge clk);
        #2;
        op_valid = 1'b0; rd_req = 1'b0; flush = 1'b0;
        reset = 1'b0;
        #1;
        check("areset_md_start", md_start, 1'b0);
        check("areset_op_ready", op_ready, 1'b1);
        check("areset_rd_valid", rd_valid, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        pend.delete();
        busy_until = 0;
        m_hilo = '0;
        idle(2, 1'b0);

        // divide by zero keeps HI/LO
        issue(mtSetLO, 32'hABCD, 32'd0, 1'b0);
        run_op("div0_latency", mtDiv, 32'd5, 32'd0, 10);
        read_const("div0_lo", 1'b0, 32'hABCD);
        read_const("div0_hi", 1'b1, 32'd0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0]  c;
            logic [31:0] a, b;
            c = codes[$urandom_range(0, 9)];
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            step($urandom_range(0, 99) < 35, c, a, b,
                 $urandom_range(0, 99) < 40, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 99) < 4);
        end
        idle(15, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
